// File: rtl/scrambler_66b_param.sv
// Self-synchronising 64b/66b scrambler/descrambler (1 + x^39 + x^58) with a
// single-register valid/ready output stage, bypass, seed load and header check.
module scrambler_66b_param #(
    parameter int          PAYLOAD_W = 64,
    parameter bit          MODE      = 1'b0,
    parameter logic [57:0] SEED      = 58'h3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [PAYLOAD_W+1:0] data_i,
    input  logic                 data_vld_i,
    output logic                 data_rdy_o,
    output logic [PAYLOAD_W+1:0] data_o,
    output logic                 data_vld_o,
    input  logic                 data_rdy_i,
    input  logic                 bypass_i,
    input  logic                 seed_load_i,
    input  logic [57:0]          seed_i,
    input  logic                 hdr_chk_i,
    output logic [15:0]          hdr_err_cnt_o,
    input  logic                 hdr_err_clr_i
);

    localparam int XW = PAYLOAD_W + 58;

    logic [57:0]          h_q;
    logic [57:0]          h_next;
    logic [XW-1:0]        x_ext;
    logic [PAYLOAD_W-1:0] pay_in;
    logic [PAYLOAD_W-1:0] pay_scr;
    logic [PAYLOAD_W-1:0] pay_out;
    logic [PAYLOAD_W+1:0] data_q;
    logic                 vld_q;
    logic                 accept;

    assign pay_in     = data_i[PAYLOAD_W+1:2];
    assign data_rdy_o = ~vld_q | data_rdy_i;
    assign accept     = data_vld_i & data_rdy_o;
    assign data_o     = data_q;
    assign data_vld_o = vld_q;

    // x_ext[m] is line bit x(m-58): the low 58 entries are the history with
    // the oldest bit at index 0, the upper entries are this beat's line bits.
    // NOTE: blocking assignments are required here; each bit of the chain
    // reads line bits produced earlier in the same loop.
    always_comb begin
        x_ext   = '0;
        pay_scr = '0;
        h_next  = '0;
        for (int m = 0; m < 58; m++) begin
            x_ext[m] = h_q[57-m];
        end
        for (int i = 0; i < PAYLOAD_W; i++) begin
            pay_scr[i]    = pay_in[i] ^ x_ext[i+19] ^ x_ext[i];
            x_ext[i+58]   = MODE ? pay_in[i] : pay_scr[i];
        end
        for (int j = 0; j < 58; j++) begin
            h_next[j] = x_ext[57+PAYLOAD_W-j];
        end
    end

    assign pay_out = bypass_i ? pay_in : pay_scr;

    // Output register: holds while stalled, drops valid once consumed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else if (accept) begin
            data_q <= {pay_out, data_i[1:0]};
            vld_q  <= 1'b1;
        end else if (data_rdy_i) begin
            vld_q  <= 1'b0;
        end
    end

    // Seed load takes precedence over the beat's own history update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q <= SEED;
        end else if (seed_load_i) begin
            h_q <= seed_i;
        end else if (accept && !bypass_i) begin
            h_q <= h_next;
        end
    end

    if (MODE) begin : g_hdr_chk
        logic [15:0] cnt_q;
        logic        bad_hdr;

        assign bad_hdr = accept & hdr_chk_i & (data_i[1] == data_i[0]);

        always_ff @(posedge clk_i) begin
            if (rst_i || hdr_err_clr_i) begin
                cnt_q <= '0;
            end else if (bad_hdr && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end

        assign hdr_err_cnt_o = cnt_q;
    end else begin : g_no_hdr_chk
        logic unused_hdr;
        assign unused_hdr    = hdr_chk_i ^ hdr_err_clr_i;
        assign hdr_err_cnt_o = '0;
    end

endmodule

// File: tb/tb_scrambler_66b_param.sv
// Scoreboard bench for scrambler_66b_param: 64-bit and 32-bit scramblers,
// chained descramblers for round trips, and a descrambler for header counting.
module tb_scrambler_66b_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // 64-bit scrambler
    logic [65:0] scr_din = '0;
    logic        scr_vld = 1'b0, scr_byp = 1'b0, scr_sl = 1'b0, scr_rdy = 1'b1;
    logic [57:0] scr_seed = '0;
    logic [65:0] scr_dout;
    logic        scr_rdy_o, scr_vld_o;
    logic [15:0] scr_cnt;
    // 64-bit descrambler chained behind it
    logic [65:0] dsc_dout;
    logic        dsc_rdy_o, dsc_vld_o;
    logic [15:0] dsc_cnt;
    // 32-bit scrambler / descrambler pair
    logic [33:0] s32_din = '0;
    logic        s32_vld = 1'b0;
    logic [33:0] s32_dout, d32_dout;
    logic        s32_rdy_o, s32_vld_o, d32_rdy_o, d32_vld_o;
    logic [15:0] s32_cnt, d32_cnt;
    // 32-bit descrambler for header counting
    logic [33:0] hd_din = '0;
    logic        hd_vld = 1'b0, hd_chk = 1'b0, hd_clr = 1'b0;
    logic [33:0] hd_dout;
    logic        hd_rdy_o, hd_vld_o;
    logic [15:0] hd_cnt;

    scrambler_66b_param #(.PAYLOAD_W(64), .MODE(1'b0), .SEED(58'h3)) u_scr (
        .clk_i(clk), .rst_i(rst), .data_i(scr_din), .data_vld_i(scr_vld),
        .data_rdy_o(scr_rdy_o), .data_o(scr_dout), .data_vld_o(scr_vld_o),
        .data_rdy_i(scr_rdy), .bypass_i(scr_byp), .seed_load_i(scr_sl),
        .seed_i(scr_seed), .hdr_chk_i(1'b1), .hdr_err_cnt_o(scr_cnt),
        .hdr_err_clr_i(1'b0));

    scrambler_66b_param #(.PAYLOAD_W(64), .MODE(1'b1), .SEED(58'h2AA)) u_dsc (
        .clk_i(clk), .rst_i(rst), .data_i(scr_dout), .data_vld_i(scr_vld_o & scr_rdy),
        .data_rdy_o(dsc_rdy_o), .data_o(dsc_dout), .data_vld_o(dsc_vld_o),
        .data_rdy_i(1'b1), .bypass_i(1'b0), .seed_load_i(1'b0),
        .seed_i(58'h0), .hdr_chk_i(1'b0), .hdr_err_cnt_o(dsc_cnt),
        .hdr_err_clr_i(1'b0));

    scrambler_66b_param #(.PAYLOAD_W(32), .MODE(1'b0), .SEED(58'h3)) u_s32 (
        .clk_i(clk), .rst_i(rst), .data_i(s32_din), .data_vld_i(s32_vld),
        .data_rdy_o(s32_rdy_o), .data_o(s32_dout), .data_vld_o(s32_vld_o),
        .data_rdy_i(1'b1), .bypass_i(1'b0), .seed_load_i(1'b0),
        .seed_i(58'h0), .hdr_chk_i(1'b0), .hdr_err_cnt_o(s32_cnt),
        .hdr_err_clr_i(1'b0));

    scrambler_66b_param #(.PAYLOAD_W(32), .MODE(1'b1), .SEED(58'h2AA)) u_d32 (
        .clk_i(clk), .rst_i(rst), .data_i(s32_dout), .data_vld_i(s32_vld_o),
        .data_rdy_o(d32_rdy_o), .data_o(d32_dout), .data_vld_o(d32_vld_o),
        .data_rdy_i(1'b1), .bypass_i(1'b0), .seed_load_i(1'b0),
        .seed_i(58'h0), .hdr_chk_i(1'b0), .hdr_err_cnt_o(d32_cnt),
        .hdr_err_clr_i(1'b0));

    scrambler_66b_param #(.PAYLOAD_W(32), .MODE(1'b1), .SEED(58'h3)) u_hdr (
        .clk_i(clk), .rst_i(rst), .data_i(hd_din), .data_vld_i(hd_vld),
        .data_rdy_o(hd_rdy_o), .data_o(hd_dout), .data_vld_o(hd_vld_o),
        .data_rdy_i(1'b1), .bypass_i(1'b0), .seed_load_i(1'b0),
        .seed_i(58'h0), .hdr_chk_i(hd_chk), .hdr_err_cnt_o(hd_cnt),
        .hdr_err_clr_i(hd_clr));

    int errors = 0;
    int checks = 0;

    logic [65:0] sb64[$];
    logic [33:0] sb32[$];
    logic [63:0] rt64[$];
    logic [31:0] rt32[$];
    logic [57:0] m_h   = 58'h3;
    logic [57:0] m_h32 = 58'h3;
    bit          rt_on = 1'b0;
    int          rt64_idx = 0;
    int          rt32_idx = 0;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Serial shift-register reference: s[0] is the newest line bit.
    task automatic ref_beat(input logic [63:0] din, input int w, input bit mode,
                            input logic [57:0] h_in, output logic [63:0] dout,
                            output logic [57:0] h_out);
        logic [57:0] s;
        logic        fb;
        s    = h_in;
        dout = '0;
        for (int i = 0; i < w; i++) begin
            fb      = s[38] ^ s[57];
            dout[i] = din[i] ^ fb;
            s       = {s[56:0], mode ? din[i] : dout[i]};
        end
        h_out = s;
    endtask

    task automatic send(input logic [63:0] pay, input logic [1:0] hdr, input bit byp,
                        input bit sl, input logic [57:0] sd);
        logic [63:0] exp_pay;
        logic [57:0] hn;
        bit          ok;
        ref_beat(pay, 64, 1'b0, m_h, exp_pay, hn);
        if (byp) exp_pay = pay;
        sb64.push_back({exp_pay, hdr});
        if (sl) m_h = sd;
        else if (!byp) m_h = hn;
        scr_din  = {pay, hdr};
        scr_vld  = 1'b1;
        scr_byp  = byp;
        scr_sl   = sl;
        scr_seed = sd;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = scr_rdy_o;
            @(posedge clk);
            #1;
        end
        check("accept", {65'b0, ok}, 66'd1);
        scr_vld = 1'b0;
        scr_byp = 1'b0;
        scr_sl  = 1'b0;
    endtask

    task automatic hbeat(input logic [1:0] hdr, input bit vld, input bit chk, input bit clr);
        hd_din = {32'hA5A5_0F0F, hdr};
        hd_vld = vld;
        hd_chk = chk;
        hd_clr = clr;
        @(posedge clk);
        #1;
        hd_vld = 1'b0;
        hd_chk = 1'b0;
        hd_clr = 1'b0;
    endtask

    // Monitor for the 64-bit scrambler: stall stability and scoreboard pops.
    bit          hold = 1'b0;
    logic [65:0] hold_data;
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("stall_vld", {65'b0, scr_vld_o}, 66'd1);
                check("stall_data", scr_dout, hold_data);
            end
            if (scr_vld_o && !scr_rdy) check("stall_rdy_o", {65'b0, scr_rdy_o}, 66'd0);
            if (scr_vld_o && scr_rdy) begin
                if (sb64.size() == 0) check("sb64_unexpected", 66'd1, 66'd0);
                else check("scr64_data", scr_dout, sb64.pop_front());
            end
            hold      = scr_vld_o && !scr_rdy;
            hold_data = scr_dout;
        end
    end

    always @(negedge clk) begin
        if (!rst && s32_vld_o) begin
            if (sb32.size() == 0) check("sb32_unexpected", 66'd1, 66'd0);
            else check("scr32_data", {32'b0, s32_dout}, {32'b0, sb32.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (rt_on && dsc_vld_o) begin
            if (rt64.size() == 0) check("rt64_unexpected", 66'd1, 66'd0);
            else begin
                logic [63:0] e;
                e = rt64.pop_front();
                if (rt64_idx >= 1) check("rt64", {2'b0, dsc_dout[65:2]}, {2'b0, e});
                rt64_idx++;
            end
        end
        if (rt_on && d32_vld_o) begin
            if (rt32.size() == 0) check("rt32_unexpected", 66'd1, 66'd0);
            else begin
                logic [31:0] e;
                e = rt32.pop_front();
                if (rt32_idx >= 2) check("rt32", {34'b0, d32_dout[33:2]}, {34'b0, e});
                rt32_idx++;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_vld", {65'b0, scr_vld_o}, 66'd0);
        check("rst_data", scr_dout, 66'd0);
        check("rst_rdy", {65'b0, scr_rdy_o}, 66'd1);
        check("rst_hdr_cnt", {50'b0, hd_cnt}, 66'd0);

        // Hand-computed first beat from seed 3.
        send(64'h0, 2'b01, 1'b0, 1'b0, 58'h0);
        check("first_beat", scr_dout, {64'h0300_0060_0000_0000, 2'b01});
        check("first_state", {8'b0, u_scr.h_q}, {8'b0, 58'h000_0000_0600_00C0});
        @(posedge clk);
        #1;
        check("drain_vld", {65'b0, scr_vld_o}, 66'd0);

        send(64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 1'b0, 58'h0);
        send(64'hDEAD_BEEF_0123_4567, 2'b11, 1'b0, 1'b0, 58'h0);
        send(64'h8000_0000_0000_0001, 2'b01, 1'b0, 1'b0, 58'h0);

        // Seed 0 with zero payload stays zero.
        scr_sl = 1'b1;
        scr_seed = 58'h0;
        @(posedge clk);
        #1;
        scr_sl = 1'b0;
        m_h = 58'h0;
        for (int b = 0; b < 10; b++) send(64'h0, 2'b10, 1'b0, 1'b0, 58'h0);
        check("seed0_state", {8'b0, u_scr.h_q}, 66'd0);

        // Seed load coinciding with a beat, then bypass on beat 3 of 5.
        send(64'h1234_5678_9ABC_DEF0, 2'b01, 1'b0, 1'b1, 58'h2_0000_0000_1234);
        send(64'h0F0F_0F0F_0F0F_0F0F, 2'b01, 1'b0, 1'b0, 58'h0);
        send(64'hAAAA_5555_AAAA_5555, 2'b10, 1'b0, 1'b0, 58'h0);
        send(64'hCAFE_F00D_CAFE_F00D, 2'b01, 1'b1, 1'b0, 58'h0);
        send(64'h0000_0000_FFFF_FFFF, 2'b10, 1'b0, 1'b0, 58'h0);
        send(64'h0123_4567_89AB_CDEF, 2'b01, 1'b0, 1'b0, 58'h0);
        // Bypass and seed load together.
        send(64'h5A5A_5A5A_5A5A_5A5A, 2'b10, 1'b1, 1'b1, 58'h3FF_0000_0000_00A5);
        send(64'h0, 2'b01, 1'b0, 1'b0, 58'h0);

        // Backpressure: downstream stalls while beats keep arriving.
        scr_rdy = 1'b0;
        fork
            begin
                send(64'h1111_2222_3333_4444, 2'b01, 1'b0, 1'b0, 58'h0);
                send(64'h5555_6666_7777_8888, 2'b10, 1'b0, 1'b0, 58'h0);
                send(64'h9999_AAAA_BBBB_CCCC, 2'b01, 1'b0, 1'b0, 58'h0);
                send(64'hDDDD_EEEE_FFFF_0000, 2'b10, 1'b0, 1'b0, 58'h0);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                scr_rdy = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Reset while a stalled beat is held discards it.
        scr_rdy = 1'b0;
        send(64'hFEED_FACE_0000_1111, 2'b01, 1'b0, 1'b0, 58'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_vld", {65'b0, scr_vld_o}, 66'd0);
        check("midrst_data", scr_dout, 66'd0);
        sb64.delete();
        m_h = 58'h3;
        m_h32 = 58'h3;
        rst = 1'b0;
        scr_rdy = 1'b1;

        // Round trip, both widths.
        rt_on = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            logic [63:0] p64, e64;
            logic [31:0] p32;
            logic [63:0] e32;
            logic [57:0] hn;
            p64 = {$urandom, $urandom};
            p32 = $urandom;
            ref_beat(p64, 64, 1'b0, m_h, e64, hn);
            m_h = hn;
            sb64.push_back({e64, 2'b01});
            rt64.push_back(p64);
            ref_beat({32'b0, p32}, 32, 1'b0, m_h32, e32, hn);
            m_h32 = hn;
            sb32.push_back({e32[31:0], 2'b10});
            rt32.push_back(p32);
            scr_din = {p64, 2'b01};
            scr_vld = 1'b1;
            s32_din = {p32, 2'b10};
            s32_vld = 1'b1;
            @(posedge clk);
            #1;
        end
        scr_vld = 1'b0;
        s32_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rt_on = 1'b0;
        check("rt64_count", rt64_idx, 66'd1000);
        check("rt32_count", rt32_idx, 66'd1000);

        // Header error counter.
        hbeat(2'b01, 1'b1, 1'b1, 1'b0);
        hbeat(2'b00, 1'b1, 1'b1, 1'b0);
        hbeat(2'b11, 1'b1, 1'b0, 1'b0);
        hbeat(2'b10, 1'b1, 1'b1, 1'b0);
        check("hdr_cnt_one", {50'b0, hd_cnt}, 66'd1);
        hbeat(2'b11, 1'b0, 1'b1, 1'b0);
        check("hdr_novld", {50'b0, hd_cnt}, 66'd1);
        hbeat(2'b00, 1'b1, 1'b1, 1'b1);
        check("hdr_clr", {50'b0, hd_cnt}, 66'd0);
        hd_din = {32'h0, 2'b11};
        hd_vld = 1'b1;
        hd_chk = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("hdr_fffe", {50'b0, hd_cnt}, 66'h0FFFE);
        @(posedge clk);
        #1;
        check("hdr_ffff", {50'b0, hd_cnt}, 66'h0FFFF);
        repeat (5) @(posedge clk);
        #1;
        check("hdr_sat", {50'b0, hd_cnt}, 66'h0FFFF);
        hd_vld = 1'b0;
        hd_chk = 1'b0;

        check("scr_cnt_zero", {50'b0, scr_cnt}, 66'd0);
        check("sb64_drained", sb64.size(), 66'd0);
        check("sb32_drained", sb32.size(), 66'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
